// File: rtl/pipe_exc_ctrl.sv
// pipe_exc_ctrl: pipeline stall/flush sequencer with MDU busy counter and
// exception/interrupt/eret arbitration.
//   Inputs : i_clk, i_reset (sync, active-low), i_hwint, i_sr_im, i_sr_ie, i_sr_exl,
//            i_exc_code_m, i_bd_m, i_pc_m, i_eret_m, i_epc, i_hazard_stall,
//            i_mdu_start_e, i_mdu_is_div_e, i_mdu_use_d
//   Outputs: o_stall, o_exc_flush, o_redirect, o_redirect_pc, o_epc_we, o_epc_val,
//            o_cause_exc, o_cause_bd, o_exl_clr (same-cycle, gated by reset),
//            o_mdu_busy (registered)
module pipe_exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int unsigned MULT_CYC   = 5,
    parameter int unsigned DIV_CYC    = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [5:0]  i_hwint,
    input  logic [5:0]  i_sr_im,
    input  logic        i_sr_ie,
    input  logic        i_sr_exl,
    input  logic [4:0]  i_exc_code_m,
    input  logic        i_bd_m,
    input  logic [31:0] i_pc_m,
    input  logic        i_eret_m,
    input  logic [31:0] i_epc,
    input  logic        i_hazard_stall,
    input  logic        i_mdu_start_e,
    input  logic        i_mdu_is_div_e,
    input  logic        i_mdu_use_d,
    output logic        o_stall,
    output logic        o_exc_flush,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_epc_we,
    output logic [31:0] o_epc_val,
    output logic [4:0]  o_cause_exc,
    output logic        o_cause_bd,
    output logic        o_exl_clr,
    output logic        o_mdu_busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        S_RUN       = 1'b0,
        S_ERET_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_busy;
    logic               w_irq;
    logic               w_exc;
    logic               w_take;
    logic               w_eret_go;
    logic               w_flush;

    // Raw request qualification; EXL masks both interrupts and new exceptions.
    assign w_irq = (|(i_hwint & i_sr_im)) & i_sr_ie & ~i_sr_exl;
    assign w_exc = (i_exc_code_m != 5'd0) & ~i_sr_exl;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and entry decisions; ERET_HOLD blocks entry for one cycle while EXL clears.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_eret_go   = 1'b0;
        case (r_state)
            S_RUN: begin
                w_take    = w_irq | w_exc;
                w_eret_go = i_eret_m & ~(w_irq | w_exc);
                if (w_eret_go) begin
                    w_state_nxt = S_ERET_HOLD;
                end
            end
            S_ERET_HOLD: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
        if (!i_reset) begin
            w_take      = 1'b0;
            w_eret_go   = 1'b0;
            w_state_nxt = S_RUN;
        end
    end

    assign w_flush = w_take | w_eret_go;

    // MDU busy counter: a flushed start is dropped, an in-flight count always runs out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_reset) begin
            w_cnt_nxt = '0;
        end else if (i_mdu_start_e && !w_flush) begin
            w_cnt_nxt = i_mdu_is_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    // Flush always wins over stall so the handler fetch is never frozen.
    assign o_stall       = i_reset & ~w_flush &
                           (i_hazard_stall | (i_mdu_use_d & ((r_cnt != '0) | i_mdu_start_e)));
    assign o_exc_flush   = w_flush;
    assign o_redirect    = w_flush;
    assign o_redirect_pc = w_take ? HANDLER_PC : (w_eret_go ? i_epc : 32'd0);
    assign o_epc_we      = w_take;
    assign o_epc_val     = i_reset ? (i_bd_m ? (i_pc_m - 32'd4) : i_pc_m) : 32'd0;
    assign o_cause_exc   = (i_reset && !w_irq) ? i_exc_code_m : 5'd0;
    assign o_cause_bd    = i_reset & i_bd_m;
    assign o_exl_clr     = w_eret_go;
    assign o_mdu_busy    = r_busy;

endmodule
